// File: rtl/frame_sched.sv
// frame_sched: frame-level sequencer for the image-FIFO read path, with a Wishbone register
// file and frame-stable shadows. Define FRAME_SCHED_DOUBLE_BUFFER_EN to enable BASE1 and SWAP.
module frame_sched #(
  parameter int AW        = 24,
  parameter int LGFLEN    = 11,
  parameter int LW        = 11,
  parameter int NF_CYCLES = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [2:0]      i_wb_addr,
  input  logic [31:0]     i_wb_data,
  output logic            o_wb_ack,
  output logic            o_wb_stall,
  output logic [31:0]     o_wb_data,
  input  logic            i_frame_start,
  input  logic            i_fifo_err,
  output logic            o_newframe,
  output logic [AW-1:0]   o_baseaddr,
  output logic [AW-1:0]   o_lineaddr,
  output logic [LGFLEN:0] o_linewords,
  output logic [LW-1:0]   o_nlines,
  output logic            o_swap_ack,
  output logic            o_buf
);

  localparam logic [2:0] S_DISABLED = 3'd0;
  localparam logic [2:0] S_WAIT     = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_ACTIVE   = 3'd4;
  localparam logic [7:0] HOLD_LAST  = 8'(NF_CYCLES - 2);

  logic [2:0]      state;
  logic [7:0]      hold_cnt;
  logic            en;
  logic [AW-1:0]   base0;
  logic [AW-1:0]   base1;
  logic [AW-1:0]   lineaddr;
  logic [LGFLEN:0] linewords;
  logic [LW-1:0]   nlines;
  logic [15:0]     errcnt;
  logic            swap_pending;
  logic            buf_sel;
  logic            swap_ack;
  logic [AW-1:0]   load_base;
  logic            bus_req;
  logic            bus_wr;
  logic            ctrl_wr;
  logic            start_load;
  logic [31:0]     rd_data;

  wire unused_wb_data = &{1'b0, i_wb_data};

  assign bus_req    = i_wb_cyc & i_wb_stb;
  assign bus_wr     = bus_req & i_wb_we;
  assign ctrl_wr    = bus_wr && (i_wb_addr == 3'd0);
  assign start_load = i_frame_start && en && ((state == S_WAIT) || (state == S_ACTIVE));
  assign o_newframe = (state == S_DISABLED) || (state == S_LOAD) || (state == S_HOLD);
  assign o_wb_stall = 1'b0;
  assign o_buf      = buf_sel;
  assign o_swap_ack = swap_ack;

  // LOAD is entered on the edge that samples the start, so shadows update together with it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_DISABLED;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_DISABLED: if (en) state <= S_WAIT;
        S_WAIT, S_ACTIVE: begin
          if (!en)
            state <= S_DISABLED;
          else if (i_frame_start)
            state <= S_LOAD;
        end
        S_LOAD: begin
          state    <= S_HOLD;
          hold_cnt <= '0;
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST)
            state <= en ? S_ACTIVE : S_DISABLED;
          else
            hold_cnt <= hold_cnt + 8'd1;
        end
        default: state <= S_DISABLED;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      en        <= 1'b0;
      base0     <= '0;
      lineaddr  <= '0;
      linewords <= '0;
      nlines    <= '0;
    end else if (bus_wr) begin
      case (i_wb_addr)
        3'd0: en        <= i_wb_data[0];
        3'd1: base0     <= i_wb_data[AW-1:0];
        3'd3: lineaddr  <= i_wb_data[AW-1:0];
        3'd4: linewords <= i_wb_data[LGFLEN:0];
        3'd5: nlines    <= i_wb_data[LW-1:0];
        default: ;
      endcase
    end
  end

`ifdef FRAME_SCHED_DOUBLE_BUFFER_EN
  // A SWAP write during LOAD re-arms pending after the consuming edge, deferring it a frame.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      base1        <= '0;
      swap_pending <= 1'b0;
      buf_sel      <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      if (bus_wr && (i_wb_addr == 3'd2))
        base1 <= i_wb_data[AW-1:0];
      swap_pending <= (swap_pending & ~start_load) | (ctrl_wr & i_wb_data[1]);
      swap_ack     <= start_load & swap_pending;
      if (start_load && swap_pending)
        buf_sel <= ~buf_sel;
    end
  end

  assign load_base = (swap_pending ? ~buf_sel : buf_sel) ? base1 : base0;
`else
  assign base1        = '0;
  assign swap_pending = 1'b0;
  assign buf_sel      = 1'b0;
  assign swap_ack     = 1'b0;
  assign load_base    = base0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      errcnt <= '0;
    end else if (ctrl_wr && i_wb_data[3]) begin
      errcnt <= {15'd0, i_fifo_err};
    end else if (i_fifo_err && (errcnt != 16'hFFFF)) begin
      errcnt <= errcnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_baseaddr  <= '0;
      o_lineaddr  <= '0;
      o_linewords <= '0;
      o_nlines    <= '0;
    end else if (start_load) begin
      o_baseaddr  <= load_base;
      o_lineaddr  <= lineaddr;
      o_linewords <= linewords;
      o_nlines    <= nlines;
    end
  end

  always_comb begin
    rd_data = '0;
    case (i_wb_addr)
      3'd0: rd_data = {errcnt, 12'd0, 1'b0, buf_sel, swap_pending, en};
      3'd1: rd_data = 32'(base0);
      3'd2: rd_data = 32'(base1);
      3'd3: rd_data = 32'(lineaddr);
      3'd4: rd_data = 32'(linewords);
      3'd5: rd_data = 32'(nlines);
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= bus_req;
      if (bus_req)
        o_wb_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// tb_frame_sched: scoreboard bench for frame_sched; a register/frame model predicts bus read
// data and per-frame shadow loads, and independent monitors compare them as the DUT responds.
module tb_frame_sched;

  localparam int AW     = 24;
  localparam int LGFLEN = 11;
  localparam int LW     = 11;
  localparam int NF     = 4;
`ifdef FRAME_SCHED_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [2:0]      wb_addr = '0;
  logic [31:0]     wb_wdata = '0;
  logic            wb_ack, wb_stall;
  logic [31:0]     wb_rdata;
  logic            frame_start = 1'b0, fifo_err = 1'b0;
  logic            newframe;
  logic [AW-1:0]   baseaddr, lineaddr;
  logic [LGFLEN:0] linewords;
  logic [LW-1:0]   nlines;
  logic            swap_ack, buf_idx;

  always #5 clk = ~clk;

  frame_sched #(.AW(AW), .LGFLEN(LGFLEN), .LW(LW), .NF_CYCLES(NF)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
    .i_wb_data(wb_wdata), .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_data(wb_rdata),
    .i_frame_start(frame_start), .i_fifo_err(fifo_err), .o_newframe(newframe),
    .o_baseaddr(baseaddr), .o_lineaddr(lineaddr), .o_linewords(linewords),
    .o_nlines(nlines), .o_swap_ack(swap_ack), .o_buf(buf_idx)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model of the register file and the frame-stable shadows
  bit              m_en, m_pend, m_buf;
  logic [15:0]     m_err;
  logic [AW-1:0]   m_base [2];
  logic [AW-1:0]   m_la, sh_base, sh_la;
  logic [LGFLEN:0] m_lw, sh_lw;
  logic [LW-1:0]   m_nl, sh_nl;

  typedef struct { int cyc; bit rd; logic [31:0] data; } bus_t;
  typedef struct { logic [AW-1:0] base; logic [AW-1:0] la; logic [LGFLEN:0] lw;
                   logic [LW-1:0] nl; bit b; bit ack; } frm_t;
  bus_t bq[$];
  frm_t fq[$];

  int exp_swaps = 0, seen_swaps = 0, exp_frames = 0, seen_frames = 0;
  int last_start = -1000;
  bit abort_run = 1'b0;
  bit prev_nf = 1'b1;
  bit run_active = 1'b0;
  int run_len = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_buf = 0; m_err = '0;
    m_base[0] = '0; m_base[1] = '0; m_la = '0; m_lw = '0; m_nl = '0;
    sh_base = '0; sh_la = '0; sh_lw = '0; sh_nl = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {m_err, 12'd0, 1'b0, m_buf, m_pend, m_en};
      3'd1: return 32'(m_base[0]);
      3'd2: return 32'(m_base[1]);
      3'd3: return 32'(m_la);
      3'd4: return 32'(m_lw);
      3'd5: return 32'(m_nl);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [15:0] err_step(input logic [15:0] e);
    return (e == 16'hFFFF) ? e : e + 16'd1;
  endfunction

  // All stimulus tasks are entered at a negedge and return at a negedge
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input bit err = 1'b0);
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = a; wb_wdata = d; fifo_err = err;
    bq.push_back('{cyc, 1'b0, 32'd0});
    case (a)
      3'd0: begin
        m_en = d[0];
        if (DB && d[1]) m_pend = 1;
        if (d[3]) m_err = err ? 16'd1 : 16'd0;
        else if (err) m_err = err_step(m_err);
      end
      3'd1: m_base[0] = d[AW-1:0];
      3'd2: if (DB) m_base[1] = d[AW-1:0];
      3'd3: m_la = d[AW-1:0];
      3'd4: m_lw = d[LGFLEN:0];
      3'd5: m_nl = d[LW-1:0];
      default: ;
    endcase
    if (a != 3'd0 && err) m_err = err_step(m_err);
    @(negedge clk);
    wb_cyc = 0; wb_stb = 0; wb_we = 0; fifo_err = 0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = a;
    bq.push_back('{cyc, 1'b1, model_read(a)});
    @(negedge clk);
    wb_cyc = 0; wb_stb = 0;
  endtask

  task automatic pulse_start(input bit expect_load);
    frame_start = 1;
    if (expect_load) begin
      if (DB && m_pend) begin
        m_buf = ~m_buf; m_pend = 0; exp_swaps++;
        fq.push_back('{m_base[m_buf], m_la, m_lw, m_nl, m_buf, 1'b1});
      end else begin
        fq.push_back('{m_base[m_buf], m_la, m_lw, m_nl, m_buf, 1'b0});
      end
      sh_base = m_base[m_buf]; sh_la = m_la; sh_lw = m_lw; sh_nl = m_nl;
      last_start = cyc;
      exp_frames++;
    end
    @(negedge clk);
    frame_start = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic err_pulses(input int n);
    repeat (n) begin
      fifo_err = 1; m_err = err_step(m_err);
      @(negedge clk);
    end
    fifo_err = 0;
  endtask

  task automatic check_shadows(input string name);
    check_output({name, "_base"}, baseaddr, sh_base);
    check_output({name, "_lineaddr"}, lineaddr, sh_la);
    check_output({name, "_linewords"}, linewords, sh_lw);
    check_output({name, "_nlines"}, nlines, sh_nl);
    check_output({name, "_buf"}, buf_idx, m_buf);
  endtask

  // Bus monitor: every ack retires the oldest outstanding transaction
  always @(negedge clk) begin
    if (wb_ack) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_ack: got ack with no outstanding request, expected none");
      end else begin
        bus_t e;
        e = bq.pop_front();
        check_output("ack_latency", cyc, e.cyc + 1);
        if (e.rd) check_output("rd_data", wb_rdata, e.data);
      end
    end
  end

  // Frame monitor: a rising o_newframe is a restart; check its shadows and hold length
  always @(negedge clk) begin
    if (abort_run) run_active = 1'b0;
    if (!prev_nf && newframe) begin
      seen_frames++;
      if (fq.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_restart: got restart at cycle %0d, expected none", cyc);
      end else begin
        frm_t f;
        f = fq.pop_front();
        check_output("frame_base", baseaddr, f.base);
        check_output("frame_lineaddr", lineaddr, f.la);
        check_output("frame_linewords", linewords, f.lw);
        check_output("frame_nlines", nlines, f.nl);
        check_output("frame_buf", buf_idx, f.b);
        check_output("frame_swap_ack", swap_ack, f.ack);
      end
      run_active = 1'b1;
      run_len = 1;
    end else if (run_active) begin
      if (newframe) run_len++;
      else begin
        check_output("newframe_len", run_len, NF);
        run_active = 1'b0;
      end
    end
    prev_nf = newframe;
    if (swap_ack) seen_swaps++;
  end

  initial begin
    logic [31:0] la_val;
    model_reset();
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_output("rst_newframe", newframe, 1);
    check_output("rst_baseaddr", baseaddr, 0);
    check_output("rst_buf", buf_idx, 0);
    check_output("rst_swap_ack", swap_ack, 0);
    check_output("rst_stall", wb_stall, 0);
    bus_read(3'd0);

    // Enable and first restart
    la_val = 32'(2048 + $urandom_range(0, 255));
    bus_write(3'd1, 32'h1000);
    bus_write(3'd4, 32'd1280);
    bus_write(3'd5, 32'd1080);
    bus_write(3'd3, la_val);
    bus_write(3'd0, 32'h1);
    idle(3);
    check_output("no_immediate_restart", newframe, 0);
    pulse_start(1);
    idle(NF + 2);

    // Swap requested mid-frame takes effect at the next start
    bus_write(3'd2, 32'h80000);
    bus_write(3'd0, 32'h3);
    check_shadows("swap_wait");
    bus_read(3'd0);
    idle(3);
    check_shadows("swap_wait2");
    pulse_start(1);
    bus_write(3'd0, 32'h3);
    idle(NF + 2);
    bus_read(3'd0);

    // Mid-frame geometry write and a start masked by HOLD
    bus_write(3'd5, 32'd720);
    check_output("nlines_midframe", nlines, 1080);
    idle(4);
    check_output("nlines_midframe2", nlines, 1080);
    pulse_start(1);
    idle(1);
    pulse_start(0);
    idle(NF + 2);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: bus_write(3'($urandom_range(1, 7)), $urandom);
        1: bus_read(3'($urandom_range(0, 7)));
        2: bus_write(3'd0, 32'h1 | (32'($urandom_range(0, 1)) << 1) | (32'($urandom_range(0, 1)) << 3));
        3: err_pulses($urandom_range(1, 5));
        4: pulse_start((cyc - last_start) >= NF + 1);
        default: begin check_shadows("rand_shadow"); idle(1); end
      endcase
    end
    idle(NF + 2);
    bus_read(3'd0);

    // Error counter saturation and simultaneous clear plus error
    err_pulses(70000);
    bus_read(3'd0);
    bus_write(3'd0, 32'h9, 1'b1);
    bus_read(3'd0);
    idle(2);

    // Asynchronous reset during HOLD
    pulse_start((cyc - last_start) >= NF + 1);
    idle(NF + 2);
    pulse_start(1);
    idle(1);
    abort_run = 1;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_output("arst_newframe", newframe, 1);
    check_output("arst_baseaddr", baseaddr, 0);
    check_output("arst_nlines", nlines, 0);
    check_output("arst_linewords", linewords, 0);
    check_output("arst_buf", buf_idx, 0);
    check_output("arst_swap_ack", swap_ack, 0);
    check_output("arst_wb_ack", wb_ack, 0);
    check_output("arst_wb_data", wb_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    abort_run = 0;
    bus_read(3'd0);
    bus_read(3'd1);

    // BASE1 and SWAP writes, then a frame start
    bus_write(3'd1, 32'h2000);
    bus_write(3'd2, 32'h3000);
    bus_write(3'd0, 32'h3);
    bus_read(3'd2);
    bus_read(3'd0);
    idle(3);
    pulse_start(1);
    idle(NF + 3);
    check_shadows("final_shadow");

    check_output("bus_queue_empty", bq.size(), 0);
    check_output("frame_queue_empty", fq.size(), 0);
    check_output("frame_count", seen_frames, exp_frames);
    check_output("swap_ack_count", seen_swaps, exp_swaps);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
